// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, memory-access and external memory port signals shared
// by mem_port_arbiter and the logic around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ma_req;
  logic              ma_we;
  logic [ADDR_W-1:0] ma_addr;
  logic [DATA_W-1:0] ma_wdata;
  logic              ma_gnt;
  logic              ma_rvalid;
  logic [DATA_W-1:0] ma_rdata;

  logic [DATA_W-1:0] from_mem_data;
  logic [ADDR_W-1:0] to_mem_addr;
  logic [DATA_W-1:0] core_to_mem_data;
  logic              core_to_mem_write_enable;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  ma_req, ma_we, ma_addr, ma_wdata,
    input  from_mem_data,
    output if_gnt, if_rvalid, if_rdata,
    output ma_gnt, ma_rvalid, ma_rdata,
    output to_mem_addr, core_to_mem_data, core_to_mem_write_enable
  );

  modport master (
    output if_req, if_addr, if_flush,
    output ma_req, ma_we, ma_addr, ma_wdata,
    output from_mem_data,
    input  if_gnt, if_rvalid, if_rdata,
    input  ma_gnt, ma_rvalid, ma_rdata,
    input  to_mem_addr, core_to_mem_data, core_to_mem_write_enable
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data access;
// data normally wins, a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_MA, WR} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        starve_cnt;
  logic              flush_pend;
  logic              flush_pend_d;
  logic              starved;
  logic              ma_win;
  logic              if_gnt;
  logic              ma_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              if_rvalid;
  logic              ma_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic [DATA_W-1:0] ma_rdata;

  // Grants are gated by reset so they drop the moment reset asserts.
  assign starved = (starve_cnt == LIMIT);
  assign ma_win  = bus.ma_req && (!starved || !bus.if_req);
  assign ma_gnt  = reset_n && ma_win;
  assign if_gnt  = reset_n && bus.if_req && !ma_win;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (ma_gnt) begin
      mem_addr  = bus.ma_addr;
      mem_wdata = bus.ma_wdata;
      mem_we    = bus.ma_we;
    end else if (if_gnt) begin
      mem_addr  = bus.if_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
    end else if (bus.if_req && !if_gnt) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      flush_pend <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_pend <= flush_pend_d;
    end
  end

  // A flush seen while an older fetch response is on the bus is consumed by
  // that response; otherwise it is held against the fetch granted now.
  always_comb begin
    state_d      = IDLE;
    flush_pend_d = 1'b0;
    if (ma_gnt) begin
      state_d = bus.ma_we ? WR : RD_MA;
    end else if (if_gnt) begin
      state_d      = RD_IF;
      flush_pend_d = bus.if_flush && (state_q != RD_IF);
    end
  end

  always_comb begin
    if_rvalid = 1'b0;
    ma_rvalid = 1'b0;
    if_rdata  = '0;
    ma_rdata  = '0;
    case (state_q)
      RD_IF: begin
        if (!flush_pend && !bus.if_flush) begin
          if_rvalid = 1'b1;
          if_rdata  = bus.from_mem_data;
        end
      end
      RD_MA: begin
        ma_rvalid = 1'b1;
        ma_rdata  = bus.from_mem_data;
      end
      default: ;
    endcase
  end

  assign bus.if_gnt                   = if_gnt;
  assign bus.ma_gnt                   = ma_gnt;
  assign bus.to_mem_addr              = mem_addr;
  assign bus.core_to_mem_data         = mem_wdata;
  assign bus.core_to_mem_write_enable = mem_we;
  assign bus.if_rvalid                = if_rvalid;
  assign bus.if_rdata                 = if_rdata;
  assign bus.ma_rvalid                = ma_rvalid;
  assign bus.ma_rdata                 = ma_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scoreboard of expected read data is
// filled on each read grant and drained as the responses come back.
module tb_mem_port_arbiter;
  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 16;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] if_q[$];
  logic [15:0] ma_q[$];
  logic [15:0] fetch_addr;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Memory model: returns address + 0x100 one cycle after the address.
  always @(posedge clk) bus.from_mem_data <= bus.to_mem_addr + 16'h0100;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic if_req, input logic [15:0] if_addr,
                               input logic if_flush, input logic ma_req,
                               input logic ma_we, input logic [15:0] ma_addr,
                               input logic [15:0] ma_wdata);
    bus.if_req   = if_req;
    bus.if_addr  = if_addr;
    bus.if_flush = if_flush;
    bus.ma_req   = ma_req;
    bus.ma_we    = ma_we;
    bus.ma_addr  = ma_addr;
    bus.ma_wdata = ma_wdata;
  endtask

  // Called at a falling edge with inputs already applied; samples just before
  // the rising edge and returns at the next falling edge.
  task automatic runCycle(input string tag, input logic exp_if_gnt,
                          input logic exp_ma_gnt, input logic grant_squashed);
    logic [15:0] exp_data;
    logic [15:0] exp_addr;
    logic [15:0] exp_wd;
    logic        exp_we;
    #4;
    if (if_q.size() > 0) begin
      exp_data = if_q.pop_front();
      if (bus.if_flush) begin
        checkOutput({tag, " if_rvalid squash"}, 32'(bus.if_rvalid), 32'd0);
      end else begin
        checkOutput({tag, " if_rvalid"}, 32'(bus.if_rvalid), 32'd1);
        checkOutput({tag, " if_rdata"}, 32'(bus.if_rdata), 32'(exp_data));
      end
    end else begin
      checkOutput({tag, " if_rvalid idle"}, 32'(bus.if_rvalid), 32'd0);
      checkOutput({tag, " if_rdata idle"}, 32'(bus.if_rdata), 32'd0);
    end
    if (ma_q.size() > 0) begin
      exp_data = ma_q.pop_front();
      checkOutput({tag, " ma_rvalid"}, 32'(bus.ma_rvalid), 32'd1);
      checkOutput({tag, " ma_rdata"}, 32'(bus.ma_rdata), 32'(exp_data));
    end else begin
      checkOutput({tag, " ma_rvalid idle"}, 32'(bus.ma_rvalid), 32'd0);
      checkOutput({tag, " ma_rdata idle"}, 32'(bus.ma_rdata), 32'd0);
    end
    checkOutput({tag, " if_gnt"}, 32'(bus.if_gnt), 32'(exp_if_gnt));
    checkOutput({tag, " ma_gnt"}, 32'(bus.ma_gnt), 32'(exp_ma_gnt));
    exp_addr = exp_ma_gnt ? bus.ma_addr : (exp_if_gnt ? bus.if_addr : 16'h0);
    exp_wd   = exp_ma_gnt ? bus.ma_wdata : 16'h0;
    exp_we   = exp_ma_gnt && bus.ma_we;
    checkOutput({tag, " to_mem_addr"}, 32'(bus.to_mem_addr), 32'(exp_addr));
    checkOutput({tag, " core_to_mem_data"}, 32'(bus.core_to_mem_data), 32'(exp_wd));
    checkOutput({tag, " write_enable"}, 32'(bus.core_to_mem_write_enable), 32'(exp_we));
    if (exp_if_gnt && !grant_squashed) if_q.push_back(bus.if_addr + 16'h0100);
    if (exp_ma_gnt && !bus.ma_we) ma_q.push_back(bus.ma_addr + 16'h0100);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234);
    #2;
    checkOutput("reset if_gnt", 32'(bus.if_gnt), 32'd0);
    checkOutput("reset ma_gnt", 32'(bus.ma_gnt), 32'd0);
    checkOutput("reset write_enable", 32'(bus.core_to_mem_write_enable), 32'd0);
    checkOutput("reset to_mem_addr", 32'(bus.to_mem_addr), 32'd0);
    checkOutput("reset core_to_mem_data", 32'(bus.core_to_mem_data), 32'd0);
    checkOutput("reset if_rvalid", 32'(bus.if_rvalid), 32'd0);
    checkOutput("reset ma_rvalid", 32'(bus.ma_rvalid), 32'd0);
    checkOutput("reset starve_cnt", 32'(dut.starve_cnt), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      runCycle("idle", 1'b0, 1'b0, 1'b0);
      checkOutput("idle starve_cnt", 32'(dut.starve_cnt), 32'd0);
    end

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'(16'h0010 + k), 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      runCycle("fetch", 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("fetch drain", 1'b0, 1'b0, 1'b0);

    // Continuous contention: fetch wins once every STARVE_LIMIT+1 cycles.
    fetch_addr = 16'h0050;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, fetch_addr, 1'b0, 1'b1, 1'b0, 16'(16'h0300 + k), 16'h0);
      if ((k % (STARVE_LIMIT + 1)) == STARVE_LIMIT) begin
        runCycle("contend", 1'b1, 1'b0, 1'b0);
        fetch_addr = fetch_addr + 16'h1;
      end else begin
        runCycle("contend", 1'b0, 1'b1, 1'b0);
      end
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("contend drain", 1'b0, 1'b0, 1'b0);

    // Dropping the fetch request restarts the starvation count.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'h0070, 1'b0, 1'b1, 1'b0, 16'(16'h0310 + k), 16'h0);
      runCycle("drop pre", 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0320, 16'h0);
    runCycle("drop gap", 1'b0, 1'b1, 1'b0);
    checkOutput("drop starve_cnt", 32'(dut.starve_cnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 16'h0070, 1'b0, 1'b1, 1'b0, 16'(16'h0330 + k), 16'h0);
      runCycle("drop post", 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 16'h0070, 1'b0, 1'b1, 1'b0, 16'h0340, 16'h0);
    runCycle("drop forced", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("drop drain", 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0200, 16'hBEEF);
    runCycle("write", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("write after", 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("flush N", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("flush N+1", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("flush N+2", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0060, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("flush grant", 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("flush grant resp", 1'b0, 1'b0, 1'b0);
    checkOutput("flush squashed if_rvalid", 32'(if_q.size()), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("flush idle", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0061, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("flush no effect", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    runCycle("flush no effect resp", 1'b0, 1'b0, 1'b0);

    // Reset during the grant cycle: nothing may come back afterwards.
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0);
    #2;
    checkOutput("rst mid gnt before", 32'(bus.ma_gnt), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst mid ma_gnt", 32'(bus.ma_gnt), 32'd0);
    checkOutput("rst mid if_gnt", 32'(bus.if_gnt), 32'd0);
    checkOutput("rst mid to_mem_addr", 32'(bus.to_mem_addr), 32'd0);
    checkOutput("rst mid ma_rvalid", 32'(bus.ma_rvalid), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    runCycle("rst release", 1'b0, 1'b0, 1'b0);
    runCycle("rst release 2", 1'b0, 1'b0, 1'b0);

    // Reset while a data response is on the bus drops it at once.
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0410, 16'h0);
    runCycle("rst resp gnt", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #2;
    checkOutput("rst resp ma_rvalid", 32'(bus.ma_rvalid), 32'd1);
    checkOutput("rst resp ma_rdata", 32'(bus.ma_rdata), 32'(ma_q.pop_front()));
    reset_n = 1'b0;
    #1;
    checkOutput("rst resp ma_rvalid dropped", 32'(bus.ma_rvalid), 32'd0);
    checkOutput("rst resp ma_rdata dropped", 32'(bus.ma_rdata), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    runCycle("rst resp after", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
